// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/ready/done handshake.
// Optional `LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF when the result is loaded.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   last_iter;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'h0) lead = 1'b0;
            if (lead) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign last_iter = (cnt_q == CNT_W'(1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)     state_d = SHIFT;
            SHIFT: if (last_iter) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Add-3 correction on every digit, then shift {scratch, shift} left by one.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                           : scratch_q[4*i +: 4];
        end
        shifted = {adj, shift_q} << 1;
    end

    // Datapath next-values
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (64'(bin) > MAX_VAL);
                end
            end
            SHIFT: begin
                scratch_d = shifted[BCD_W+BIN_W-1 -: BCD_W];
                shift_d   = shifted[BIN_W-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    done_d     = 1'b1;
                    overflow_d = ovf_pend_q;
                    if (ovf_pend_q) begin
                        bcd_d = {DIGITS{4'h9}};
                    end else begin
`ifdef LEADING_ZERO_BLANK_EN
                        bcd_d = blank_lz(shifted[BCD_W+BIN_W-1 -: BCD_W]);
`else
                        bcd_d = shifted[BCD_W+BIN_W-1 -: BCD_W];
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Output decode
    always_comb begin
        ready    = (state_q == IDLE);
        done     = done_q;
        bcd      = bcd_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, handshake corner cases, randomized model check.
// Honors `LEADING_ZERO_BLANK_EN in its expected values.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                ready;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .ready(ready), .done(done), .bcd(bcd), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          value;
        logic [15:0] exp_plain;
        logic [15:0] exp_blank;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturate above 9999, optional leading blank.
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int          p;
        if (v > 9999) return 16'h9999;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    // One conversion; bin is scrambled after acceptance. lat=0 means no done within budget.
    task automatic do_conv(input int v, output logic [15:0] b, output logic o, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = BIN_W'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        lat   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        b = bcd;
        o = overflow;
    endtask

    initial begin
        logic [15:0] b, b_hold;
        logic        o;
        int          lat, ndone, first_k, second_k;
        logic [15:0] first_b, second_b;
        int          v;

        vecs[0] = '{0,     16'h0000, 16'hFFF0, 1'b0};
        vecs[1] = '{1234,  16'h1234, 16'h1234, 1'b0};
        vecs[2] = '{7,     16'h0007, 16'hFFF7, 1'b0};
        vecs[3] = '{9999,  16'h9999, 16'h9999, 1'b0};
        vecs[4] = '{10000, 16'h9999, 16'h9999, 1'b1};
        vecs[5] = '{16383, 16'h9999, 16'h9999, 1'b1};
        vecs[6] = '{1000,  16'h1000, 16'h1000, 1'b0};
        vecs[7] = '{10,    16'h0010, 16'hFF10, 1'b0};
        vecs[8] = '{100,   16'h0100, 16'hF100, 1'b0};
        vecs[9] = '{9,     16'h0009, 16'hFFF9, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #17;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_conv(vecs[i].value, b, o, lat);
`ifdef LEADING_ZERO_BLANK_EN
            check($sformatf("vec%0d_bcd", i), 64'(b), 64'(vecs[i].exp_blank));
`else
            check($sformatf("vec%0d_bcd", i), 64'(b), 64'(vecs[i].exp_plain));
`endif
            check($sformatf("vec%0d_ovf", i), 64'(o), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(BIN_W));
            check($sformatf("vec%0d_ready_in_done", i), 64'(ready), 64'd1);
            b_hold = bcd;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_bcd_hold", i), 64'(bcd), 64'(b_hold));
        end

        // start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = BIN_W'(42);
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first_b = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                start = 1'b1;
                bin   = BIN_W'(555);
            end
            if (k == 11) start = 1'b0;
            @(posedge clk);
            #1;
            if (k == 5) check("ignore_ready_busy", 64'(ready), 64'd0);
            if (done) begin
                ndone++;
                first_b = bcd;
            end
        end
        check("ignore_ndone", 64'(ndone), 64'd1);
        check("ignore_bcd", 64'(first_b), 64'(model_bcd(42)));

        // Back-to-back: start held, second value presented in the done cycle
        @(negedge clk);
        start = 1'b1;
        bin   = BIN_W'(12);
        @(posedge clk);
        #1;
        first_k = 0; second_k = 0; first_b = '0; second_b = '0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (first_k != 0 && k == first_k + 1) start = 1'b0;
            if (done) begin
                if (first_k == 0) begin
                    first_k = k;
                    first_b = bcd;
                    bin     = BIN_W'(34);
                end else if (second_k == 0) begin
                    second_k = k;
                    second_b = bcd;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_lat", 64'(first_k), 64'(BIN_W));
        check("b2b_spacing", 64'(second_k - first_k), 64'(BIN_W + 1));
        check("b2b_first_bcd", 64'(first_b), 64'(model_bcd(12)));
        check("b2b_second_bcd", 64'(second_b), 64'(model_bcd(34)));

        // Reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = BIN_W'(8888);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_conv(3, b, o, lat);
        check("after_abort_bcd", 64'(b), 64'(model_bcd(3)));
        check("after_abort_lat", 64'(lat), 64'(BIN_W));

        // Randomized against the reference model
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 16383));
            do_conv(v, b, o, lat);
            check($sformatf("rand%0d_bcd(%0d)", n, v), 64'(b), 64'(model_bcd(v)));
            check($sformatf("rand%0d_ovf(%0d)", n, v), 64'(o), 64'(v > 9999));
            check($sformatf("rand%0d_lat", n), 64'(lat), 64'(BIN_W));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
